// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: one shared frame counter drives N_CH servo PWM compares with clamped,
// frame-synchronous width updates. Define SERVO_SLEW_LIMIT_EN to rate-limit width changes per frame.
module servo_pwm_bank #(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 20,
    parameter int PW_W      = 17,
    parameter int PERIOD    = 1000000,
    parameter int PW_MIN    = 50000,
    parameter int PW_MAX    = 100000,
    parameter int SLEW_STEP = 500
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    wr_en,
    input  logic [$clog2(N_CH)-1:0] wr_ch,
    input  logic [PW_W-1:0]         wr_data,
    input  logic [N_CH-1:0]         ch_en,
    output logic [N_CH-1:0]         PWM,
    output logic                    frame_start,
    output logic                    settled
);

    localparam int              CH_W  = $clog2(N_CH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [PW_W-1:0]  W_MIN = PW_W'(PW_MIN);
    localparam logic [PW_W-1:0]  W_MAX = PW_W'(PW_MAX);
    localparam logic [PW_W-1:0]  W_CTR = PW_W'((PW_MIN + PW_MAX) / 2);

    // Elaboration-time parameter sanity.
    if (N_CH < 2) begin : g_bad_nch
        $error("servo_pwm_bank: N_CH must be at least 2");
    end
    if (PW_MIN > PW_MAX) begin : g_bad_minmax
        $error("servo_pwm_bank: PW_MIN must not exceed PW_MAX");
    end
    if (PW_MAX >= PERIOD) begin : g_bad_max
        $error("servo_pwm_bank: PW_MAX must be below PERIOD");
    end
    if (longint'(PERIOD) > (longint'(1) << CNT_W)) begin : g_bad_period
        $error("servo_pwm_bank: PERIOD does not fit in CNT_W bits");
    end
    if (longint'(PW_MAX) >= (longint'(1) << PW_W)) begin : g_bad_pw_w
        $error("servo_pwm_bank: PW_MAX does not fit in PW_W bits");
    end
    if (SLEW_STEP < 1) begin : g_bad_slew
        $error("servo_pwm_bank: SLEW_STEP must be positive");
    end

    function automatic logic [PW_W-1:0] clamp_pw(input logic [PW_W-1:0] v);
        logic [PW_W-1:0] r;
        r = v;
        if (v < W_MIN) r = W_MIN;
        else if (v > W_MAX) r = W_MAX;
        return r;
    endfunction

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic signed [PW_W:0] STEP_S = (PW_W + 1)'(SLEW_STEP);

    // Difference is taken one bit wider than the widths so it cannot wrap.
    function automatic logic [PW_W-1:0] slew_toward(input logic [PW_W-1:0] cur,
                                                    input logic [PW_W-1:0] goal);
        logic signed [PW_W:0] diff;
        logic [PW_W-1:0]      r;
        diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
        r    = goal;
        if (diff > STEP_S) r = cur + PW_W'(SLEW_STEP);
        else if (diff < -STEP_S) r = cur - PW_W'(SLEW_STEP);
        return r;
    endfunction
`endif

    logic [CNT_W-1:0] cnt;
    logic             boundary;
    logic [N_CH-1:0]  pwm_d;
    logic [N_CH-1:0]  match;

    assign boundary = (cnt == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= boundary ? '0 : cnt + CNT_W'(1);
            frame_start <= boundary;
        end
    end

    // wr_en is a single-cycle strobe with no backpressure: the write is always accepted
    // if wr_ch names a channel, and silently dropped otherwise.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [PW_W-1:0] tgt;
        logic [PW_W-1:0] act;
        logic [PW_W-1:0] act_next;

`ifdef SERVO_SLEW_LIMIT_EN
        assign act_next = slew_toward(act, tgt);
`else
        assign act_next = tgt;
`endif

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) tgt <= W_CTR;
            else if (wr_en && (wr_ch == CH_W'(i))) tgt <= clamp_pw(wr_data);
        end

        // Active width only moves at the frame boundary, so no pulse is ever cut short.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) act <= W_CTR;
            else if (boundary) act <= act_next;
        end

        assign pwm_d[i] = ch_en[i] & (cnt < CNT_W'(act));
        assign match[i] = (act == tgt);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PWM     <= '0;
            settled <= 1'b1;
        end else begin
            PWM     <= pwm_d;
            settled <= &match;
        end
    end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: directed frame-width scenarios plus random traffic against a frame model.
// Honours SERVO_SLEW_LIMIT_EN the same way as the design.
module tb_servo_pwm_bank;

    localparam int PERIOD    = 100;
    localparam int PW_MIN    = 10;
    localparam int PW_MAX    = 30;
    localparam int SLEW_STEP = 4;
    localparam int PW_CTR    = (PW_MIN + PW_MAX) / 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [16:0] wr_data = '0;
    logic [3:0]  ch_en = 4'hF;
    logic [3:0]  pwm;
    logic        frame_start;
    logic        settled;
    logic [2:0]  pwm3;
    logic        fs3;
    logic        set3;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: t counts clocks since reset release; [0] is the 4-channel unit, [1] the 3-channel one.
    int         t = 0;
    int         tgt[2][4];
    int         act[2][4];
    logic [11:0] exp_q[$];

    int wid[4];
    int wid3[3];
    int fs_cnt;
    logic set_mid;
    logic set3_mid;

    servo_pwm_bank #(
        .N_CH(4), .CNT_W(20), .PW_W(17), .PERIOD(PERIOD),
        .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .SLEW_STEP(SLEW_STEP)
    ) u_dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .ch_en(ch_en), .PWM(pwm), .frame_start(frame_start), .settled(settled)
    );

    // Three-channel unit so that an out-of-range wr_ch (3) is representable.
    servo_pwm_bank #(
        .N_CH(3), .CNT_W(20), .PW_W(17), .PERIOD(PERIOD),
        .PW_MIN(PW_MIN), .PW_MAX(PW_MAX), .SLEW_STEP(SLEW_STEP)
    ) u_dut3 (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .ch_en(ch_en[2:0]), .PWM(pwm3), .frame_start(fs3), .settled(set3)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_w(input int v);
        if (v < PW_MIN) return PW_MIN;
        if (v > PW_MAX) return PW_MAX;
        return v;
    endfunction

    function automatic int next_w(input int a, input int g);
        int d;
        d = g - a;
`ifdef SERVO_SLEW_LIMIT_EN
        if (d > SLEW_STEP) d = SLEW_STEP;
        else if (d < -SLEW_STEP) d = -SLEW_STEP;
`endif
        return a + d;
    endfunction

    function automatic logic all_eq(input int d, input int n);
        for (int i = 0; i < n; i++)
            if (act[d][i] != tgt[d][i]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference model: position in frame is t mod PERIOD; outputs reflect the previous position.
    initial begin
        forever begin
            @(posedge CLK or posedge RST);
            if (RST) begin
                t = 0;
                for (int d = 0; d < 2; d++)
                    for (int i = 0; i < 4; i++) begin
                        tgt[d][i] = PW_CTR;
                        act[d][i] = PW_CTR;
                    end
                exp_q.delete();
            end else begin
                int         pos;
                logic [3:0] p0;
                logic [2:0] p3;
                logic       last;
                pos  = t % PERIOD;
                last = (pos == PERIOD - 1);
                for (int i = 0; i < 4; i++) p0[i] = ch_en[i] && (pos < act[0][i]);
                for (int i = 0; i < 3; i++) p3[i] = ch_en[i] && (pos < act[1][i]);
                exp_q.push_back({all_eq(1, 3), last, 1'b0, p3, all_eq(0, 4), last, p0});
                if (last)
                    for (int d = 0; d < 2; d++)
                        for (int i = 0; i < 4; i++) act[d][i] = next_w(act[d][i], tgt[d][i]);
                if (wr_en) begin
                    if (int'(wr_ch) < 4) tgt[0][wr_ch] = clamp_w(int'(wr_data));
                    if (int'(wr_ch) < 3) tgt[1][wr_ch] = clamp_w(int'(wr_data));
                end
                t++;
            end
        end
    end

    // Scoreboard: compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (RST) begin
                chk("reset_outs", {set3, fs3, 1'b0, pwm3, settled, frame_start, pwm}, 12'h820);
            end else begin
                chk("sb_qsize", exp_q.size(), 1);
                if (exp_q.size() > 0)
                    chk("sb", {set3, fs3, 1'b0, pwm3, settled, frame_start, pwm}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_pos(input int p);
        for (int i = 0; i < 2 * PERIOD && (t % PERIOD) != p; i++) @(negedge CLK);
        chk("wait_pos", t % PERIOD, p);
    endtask

    // Measures one frame (counter 0..PERIOD-1) per channel; optionally writes and toggles ch_en[3].
    task automatic run_frame(input int wpos, input int wch, input int wdata,
                             input int off_pos, input int on_pos);
        int pos;
        wait_pos(1);
        for (int i = 0; i < 4; i++) wid[i] = 0;
        for (int i = 0; i < 3; i++) wid3[i] = 0;
        fs_cnt   = 0;
        set_mid  = 1'b0;
        set3_mid = 1'b0;
        for (int k = 0; k < PERIOD; k++) begin
            pos = t % PERIOD;
            for (int i = 0; i < 4; i++) wid[i] += int'(pwm[i]);
            for (int i = 0; i < 3; i++) wid3[i] += int'(pwm3[i]);
            fs_cnt += int'(frame_start);
            if (pos == 50) begin
                set_mid  = settled;
                set3_mid = set3;
            end
            if (off_pos >= 0 && pos == off_pos + 1) chk("en_drop", pwm[3], 0);
            wr_en   = (pos == wpos);
            wr_ch   = 2'(wch);
            wr_data = 17'(wdata);
            if (pos == off_pos) ch_en[3] = 1'b0;
            if (pos == on_pos) ch_en[3] = 1'b1;
            @(negedge CLK);
        end
        wr_en = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) chk($sformatf("%s_w%0d", tag, i), wid[i], e[i]);
        for (int i = 0; i < 3; i++) chk($sformatf("%s_d3w%0d", tag, i), wid3[i], e[i]);
        chk({tag, "_fs"}, fs_cnt, 1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;

`ifdef SERVO_SLEW_LIMIT_EN
        run_frame(-1, 0, 0, -1, -1);  check_frame("f0", 20, 20, 20, 20);
        chk("f0_set", set_mid, 1);
        run_frame(10, 0, 30, -1, -1); check_frame("slew1", 20, 20, 20, 20);
        chk("slew1_set", set_mid, 0);
        run_frame(-1, 0, 0, -1, -1);  check_frame("slew2", 24, 20, 20, 20);
        chk("slew2_set", set_mid, 0);
        run_frame(-1, 0, 0, -1, -1);  check_frame("slew3", 28, 20, 20, 20);
        chk("slew3_set", set_mid, 0);
        run_frame(-1, 0, 0, -1, -1);  check_frame("slew4", 30, 20, 20, 20);
        chk("slew4_set", set_mid, 1);
        run_frame(10, 1, 5, -1, -1);  check_frame("down1", 30, 20, 20, 20);
        run_frame(-1, 0, 0, -1, -1);  check_frame("down2", 30, 16, 20, 20);
        run_frame(-1, 0, 0, -1, -1);  check_frame("down3", 30, 12, 20, 20);
        run_frame(-1, 0, 0, -1, -1);  check_frame("down4", 30, 10, 20, 20);
        chk("down4_set", set_mid, 1);
`else
        run_frame(-1, 0, 0, -1, -1);  check_frame("f0", 20, 20, 20, 20);
        chk("f0_set", set_mid, 1);
        run_frame(40, 1, 25, -1, -1); check_frame("midwr", 20, 20, 20, 20);
        chk("midwr_set", set_mid, 0);
        run_frame(-1, 0, 0, -1, -1);  check_frame("midwr_next", 20, 25, 20, 20);
        chk("midwr_next_set", set_mid, 1);
        run_frame(10, 0, 5, -1, -1);  check_frame("clamp_lo_wr", 20, 25, 20, 20);
        run_frame(10, 0, 200, -1, -1); check_frame("clamp_lo", 10, 25, 20, 20);
        run_frame(10, 3, 12, -1, -1); check_frame("clamp_hi", 30, 25, 20, 20);
        chk("oor_main_set", set_mid, 0);
        chk("oor_set", set3_mid, 1);
        run_frame(99, 2, 12, -1, -1); check_frame("bnd_wr", 30, 25, 20, 12);
        run_frame(-1, 0, 0, -1, -1);  check_frame("bnd_next", 30, 25, 20, 12);
        run_frame(-1, 0, 0, -1, -1);  check_frame("bnd_after", 30, 25, 12, 12);
`endif

        // Reset mid-frame with a pending target change outstanding.
        wait_pos(3);
        wr_en = 1'b1; wr_ch = 2'd2; wr_data = 17'd28;
        @(negedge CLK);
        wr_en = 1'b0;
        @(negedge CLK);
        chk("pre_rst_pwm", pwm, 4'hF);
        chk("pre_rst_set", settled, 0);
        RST = 1'b1;
        #1;
        chk("rst_now_pwm", pwm, 0);
        chk("rst_now_pwm3", pwm3, 0);
        chk("rst_now_set", settled, 1);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        run_frame(-1, 0, 0, -1, -1);  check_frame("post_rst", 20, 20, 20, 20);
        run_frame(-1, 0, 0, 5, 8);    check_frame("enable", 20, 20, 20, 17);

        // Random traffic, including occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = 2'($urandom_range(0, 3));
            wr_data = ($urandom_range(0, 7) == 0) ? 17'($urandom_range(0, 131071))
                                                  : 17'($urandom_range(0, 40));
            if ($urandom_range(0, 49) == 0) ch_en = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) begin
                RST = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge CLK);
                RST = 1'b0;
            end
            @(negedge CLK);
        end
        wr_en = 1'b0;
        repeat (5) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
